// File: rtl/result_output_stage.sv
// Registered output stage: encodes error/overflow as a status, zeroes flagged results
// and buffers them in a DEPTH-entry valid/ready FIFO. Optional counters: STATUS_CNT_EN.
module result_output_stage #(
  parameter int BITS  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rsn,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [BITS-1:0]            i_arg_result,
  input  logic                       i_error,
  input  logic                       i_overflow,
  input  logic [1:0]                 i_op,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [BITS-1:0]            o_result,
  output logic [1:0]                 o_op,
  output logic [1:0]                 o_status,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic                       i_cnt_clr,
  output logic [CNT_W-1:0]           o_err_cnt,
  output logic [CNT_W-1:0]           o_ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_OVF = 2'b10;

  typedef struct packed {
    logic [BITS-1:0] result;
    logic [1:0]      op;
    logic [1:0]      status;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             entry_in, head, hold_q;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop;

  assign o_ready = (count != CW'(DEPTH));
  assign o_valid = (count != '0);
  assign o_count = count;
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  // Error outranks overflow; any flagged result is stored as zero so X never escapes.
  always_comb begin
    entry_in.op     = i_op;
    entry_in.status = i_error ? ST_ERR : (i_overflow ? ST_OVF : ST_OK);
    entry_in.result = (entry_in.status == ST_OK) ? i_arg_result : '0;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge i_clk) begin
      if (push && wr_ptr == AW'(g)) mem[g] <= entry_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

  // Last shown head, so outputs hold when the FIFO drains and read 0 after reset.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn)       hold_q <= '0;
    else if (o_valid) hold_q <= head;
  end

  assign o_result = o_valid ? head.result : hold_q.result;
  assign o_op     = o_valid ? head.op     : hold_q.op;
  assign o_status = o_valid ? head.status : hold_q.status;

`ifdef STATUS_CNT_EN
  logic [CNT_W-1:0] err_q, ovf_q;

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      err_q <= '0;
      ovf_q <= '0;
    end else if (i_cnt_clr) begin
      err_q <= '0;
      ovf_q <= '0;
    end else if (push) begin
      if (entry_in.status == ST_ERR && err_q != '1) err_q <= err_q + 1'b1;
      if (entry_in.status == ST_OVF && ovf_q != '1) ovf_q <= ovf_q + 1'b1;
    end
  end

  assign o_err_cnt = err_q;
  assign o_ovf_cnt = ovf_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign o_err_cnt = '0;
  assign o_ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_result_output_stage.sv
// Directed bench for result_output_stage (BITS=32, DEPTH=2, CNT_W=8).
module tb_result_output_stage;
  logic        i_clk = 1'b0;
  logic        i_rsn;
  logic        i_valid, i_error, i_overflow, i_ready, i_cnt_clr;
  logic [31:0] i_arg_result;
  logic [1:0]  i_op;
  logic        o_ready, o_valid;
  logic [31:0] o_result;
  logic [1:0]  o_op, o_status;
  logic [1:0]  o_count;
  logic [7:0]  o_err_cnt, o_ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  result_output_stage #(.BITS(32), .DEPTH(2), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rsn(i_rsn), .i_valid(i_valid), .o_ready(o_ready),
    .i_arg_result(i_arg_result), .i_error(i_error), .i_overflow(i_overflow),
    .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_op(o_op), .o_status(o_status), .o_count(o_count), .i_cnt_clr(i_cnt_clr),
    .o_err_cnt(o_err_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic e,
                       input logic ov, input logic [1:0] op);
    i_valid = v; i_arg_result = r; i_error = e; i_overflow = ov; i_op = op;
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [31:0] r,
                          input logic [1:0] st, input logic [1:0] cnt);
    chk({tag, ".valid"},  64'(o_valid),  64'(v));
    chk({tag, ".result"}, 64'(o_result), 64'(r));
    chk({tag, ".status"}, 64'(o_status), 64'(st));
    chk({tag, ".count"},  64'(o_count),  64'(cnt));
  endtask

  initial begin
    i_rsn = 1'b0; i_ready = 1'b0; i_cnt_clr = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    #3;
    chk_outs("reset", 1'b0, 32'h0, 2'b00, 2'd0);
    chk("reset.ready", 64'(o_ready), 64'd1);
    chk("reset.op", 64'(o_op), 64'd0);
    chk("reset.errcnt", 64'(o_err_cnt), 64'd0);
    chk("reset.ovfcnt", 64'(o_ovf_cnt), 64'd0);
    @(negedge i_clk); i_rsn = 1'b1;
    step();

    // single pass-through
    i_ready = 1'b1;
    drive(1'b1, 32'h0000_00F0, 1'b0, 1'b0, 2'd1);
    step();
    chk_outs("passA", 1'b1, 32'h0000_00F0, 2'b00, 2'd1);
    chk("passA.op", 64'(o_op), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    step();
    chk_outs("passA.drain", 1'b0, 32'h0000_00F0, 2'b00, 2'd0);

    // fill, drop when full, drain in order
    i_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 1'b0, 2'd2); step();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 2'd3); step();
    chk("full.count", 64'(o_count), 64'd2);
    chk("full.ready", 64'(o_ready), 64'd0);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 2'd0); step();
    chk_outs("full.drop", 1'b1, 32'h11, 2'b00, 2'd2);
    chk("full.op", 64'(o_op), 64'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    i_ready = 1'b1; step();
    chk_outs("drain1", 1'b1, 32'h22, 2'b00, 2'd1);
    chk("drain1.op", 64'(o_op), 64'd3);
    step();
    chk_outs("drain2", 1'b0, 32'h22, 2'b00, 2'd0);
    chk("drain2.ready", 64'(o_ready), 64'd1);

    // status encoding and sanitisation
    i_ready = 1'b0;
    drive(1'b1, 32'hxxxx_xxxx, 1'b1, 1'b1, 2'd1); step();
    chk_outs("errovf", 1'b1, 32'h0, 2'b01, 2'd1);
    drive(1'b1, 32'h55, 1'b0, 1'b1, 2'd2); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    i_ready = 1'b1; step();
    chk_outs("ovf", 1'b1, 32'h0, 2'b10, 2'd1);
    step();
    chk("ovf.drain", 64'(o_valid), 64'd0);

    // simultaneous push/pop at count 1
    i_ready = 1'b0;
    drive(1'b1, 32'hE1, 1'b0, 1'b0, 2'd0); step();
    chk_outs("pp.pre", 1'b1, 32'hE1, 2'b00, 2'd1);
    drive(1'b1, 32'hF2, 1'b0, 1'b0, 2'd1);
    i_ready = 1'b1; step();
    chk_outs("pp.post", 1'b1, 32'hF2, 2'b00, 2'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0); step();
    chk("pp.drain", 64'(o_count), 64'd0);

    // async reset with two entries held
    i_ready = 1'b0;
    drive(1'b1, 32'h77, 1'b0, 1'b0, 2'd3); step();
    drive(1'b1, 32'h88, 1'b0, 1'b0, 2'd3); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    chk("rst2.pre", 64'(o_count), 64'd2);
    i_rsn = 1'b0; #1;
    chk_outs("rst2", 1'b0, 32'h0, 2'b00, 2'd0);
    chk("rst2.ready", 64'(o_ready), 64'd1);
    chk("rst2.op", 64'(o_op), 64'd0);
    @(negedge i_clk); i_rsn = 1'b1;
    i_ready = 1'b1; step();
    chk_outs("rst2.after", 1'b0, 32'h0, 2'b00, 2'd0);

    // status counters
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'h1, 1'b1, 1'b0, 2'd0);
      step();
    end
`ifdef STATUS_CNT_EN
    chk("cnt.sat", 64'(o_err_cnt), 64'd255);
    chk("cnt.ovf0", 64'(o_ovf_cnt), 64'd0);
    i_cnt_clr = 1'b1; step();
    chk("cnt.clr", 64'(o_err_cnt), 64'd0);
    i_cnt_clr = 1'b0;
    drive(1'b1, 32'h1, 1'b0, 1'b1, 2'd0); step();
    chk("cnt.ovf1", 64'(o_ovf_cnt), 64'd1);
    chk("cnt.err0", 64'(o_err_cnt), 64'd0);
`else
    chk("cnt.off.err", 64'(o_err_cnt), 64'd0);
    i_cnt_clr = 1'b1;
    drive(1'b1, 32'h1, 1'b0, 1'b1, 2'd0); step();
    chk("cnt.off.ovf", 64'(o_ovf_cnt), 64'd0);
    i_cnt_clr = 1'b0;
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0); step();
    chk("end.empty", 64'(o_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
